// File: rtl/cdda_ring_interface_pkg.sv
// Shared definitions for the CD-DA ring interface: register map, CTRL/STATUS
// bit positions and register reset constants.
package cdda_ring_interface_pkg;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_STATUS   = 3'd1,
    REG_RDPOS    = 3'd2,
    REG_WRPOS    = 3'd3,
    REG_LEVEL    = 3'd4,
    REG_LOWWATER = 3'd5,
    REG_SCRATCH  = 3'd6,
    REG_IRQCLR   = 3'd7
  } reg_addr_e;

  localparam int CTRL_ENABLE        = 0;
  localparam int CTRL_CLR_UNDERFLOW = 1;
  localparam int CTRL_DMA_MODE      = 2;
  localparam int CTRL_MUTE          = 3;
  localparam int CTRL_IRQ_EN        = 4;
  localparam int CTRL_FLUSH         = 5;

  localparam int ST_ENABLED    = 0;
  localparam int ST_UNDERFLOW  = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_LW_PENDING = 3;
  localparam int ST_EMPTY      = 4;
  localparam int ST_FULL       = 5;

  localparam logic [7:0] SCRATCH_RESET = 8'h55;

endpackage

// File: rtl/cdda_ring_interface_frame_ram.sv
// Byte-writable frame store with a registered full-frame read port.
// Storage is never reset; only the read register is.
module cdda_frame_ram #(
  parameter int CHANNELS   = 2,
  parameter int DEPTH_LOG2 = 8,
  localparam int CH_LOG2   = $clog2(CHANNELS),
  localparam int BAW       = DEPTH_LOG2 + CH_LOG2 + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [BAW-1:0]          waddr,
  input  logic [7:0]              wdata,
  input  logic [DEPTH_LOG2-1:0]   rd_frame,
  output logic [CHANNELS*16-1:0]  rd_data
);

  localparam int BYTES = 2 ** BAW;

  logic [7:0]             mem [BYTES];
  logic [CHANNELS*16-1:0] rd_d, rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Byte i of the frame lands at bits [8i+7:8i], so channel c is little-endian at [16c+15:16c].
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < CHANNELS * 2; i++) begin
      rd_d[8*i +: 8] = mem[{rd_frame, i[CH_LOG2:0]}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/cdda_ring_interface.sv
// CD-DA sample ring: CPU register/buffer window, DMA frame writer and the
// frame-at-a-time read side feeding the audio serializer.
module cdda_ring_interface
  import cdda_ring_interface_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DEPTH_LOG2 = 8,
  localparam int AW        = DEPTH_LOG2 + $clog2(CHANNELS) + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AW-1:0]          sram_a,
  input  logic [7:0]             sram_d_in,
  output logic [7:0]             sram_d_out,
  input  logic                   sram_cs,
  input  logic                   sram_oe,
  input  logic                   sram_we,
  output logic                   sram_wait,
  input  logic [7:0]             dma_data,
  input  logic                   dma_strobe,
  input  logic                   consume,
  output logic [CHANNELS*16-1:0] out_data,
  output logic                   out_enable,
  output logic                   irq
);

  localparam int CH_LOG2 = $clog2(CHANNELS);
  localparam int BW      = CH_LOG2 + 1;
  localparam int BAW     = AW - 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(CHANNELS * 2 - 1);

  logic                  enable_q, enable_d, dma_mode_q, dma_mode_d;
  logic                  mute_q, mute_d, irq_en_q, irq_en_d;
  logic                  underflow_q, underflow_d, overrun_q, overrun_d;
  logic                  lw_pending_q, lw_pending_d, out_enable_q, out_enable_d;
  logic [DEPTH_LOG2-1:0] rdpos_q, rdpos_d, wrpos_q, wrpos_d;
  logic [BW-1:0]         bytecnt_q, bytecnt_d;
  logic [7:0]            lowwater_q, lowwater_d, scratch_q, scratch_d;

  logic                  reg_wr, buf_wr, flush;
  logic                  wr_ctrl, wr_rdpos, wr_wrpos, wr_lowwater, wr_scratch, wr_irqclr;
  reg_addr_e             reg_sel;
  logic [DEPTH_LOG2-1:0] level, level_next;
  logic [7:0]            level_b, level_next_b, rdpos_b, wrpos_b;
  logic                  empty, full;
  logic                  consume_ok, adv, dma_wr, frame_done;
  logic                  ram_we;
  logic [BAW-1:0]        ram_waddr;
  logic [7:0]            ram_wdata;
  logic [CHANNELS*16-1:0] ram_rd_data;

  always_comb begin
    reg_sel     = reg_addr_e'(sram_a[2:0]);
    buf_wr      = sram_cs & sram_we & sram_a[AW-1];
    reg_wr      = sram_cs & sram_we & ~sram_a[AW-1];
    wr_ctrl     = reg_wr & (reg_sel == REG_CTRL);
    wr_rdpos    = reg_wr & (reg_sel == REG_RDPOS);
    wr_wrpos    = reg_wr & (reg_sel == REG_WRPOS);
    wr_lowwater = reg_wr & (reg_sel == REG_LOWWATER);
    wr_scratch  = reg_wr & (reg_sel == REG_SCRATCH);
    wr_irqclr   = reg_wr & (reg_sel == REG_IRQCLR);
    flush       = wr_ctrl & sram_d_in[CTRL_FLUSH];

    level       = wrpos_q - rdpos_q;
    empty       = (level == '0);
    full        = (level == '1);
    consume_ok  = consume & enable_q;
    adv         = consume_ok & ~empty;
    dma_wr      = dma_mode_q & dma_strobe & ~full;
    frame_done  = dma_wr & (bytecnt_q == LAST_BYTE);
  end

  // Pointer updates: internal advances first, CPU pointer writes and flush override them.
  always_comb begin
    rdpos_d   = rdpos_q;
    wrpos_d   = wrpos_q;
    bytecnt_d = bytecnt_q;
    if (adv)        rdpos_d = rdpos_q + 1'b1;
    if (dma_wr) begin
      bytecnt_d = frame_done ? '0 : bytecnt_q + 1'b1;
      if (frame_done) wrpos_d = wrpos_q + 1'b1;
    end
    if (wr_rdpos)   rdpos_d = sram_d_in[DEPTH_LOG2-1:0];
    if (wr_wrpos) begin
      wrpos_d   = sram_d_in[DEPTH_LOG2-1:0];
      bytecnt_d = '0;
    end
    if (flush) begin
      rdpos_d   = wrpos_q;
      bytecnt_d = '0;
    end
    level_next = wrpos_d - rdpos_d;
  end

  // Control/status registers; hardware set events win over software clears.
  always_comb begin
    enable_d     = enable_q;
    dma_mode_d   = dma_mode_q;
    mute_d       = mute_q;
    irq_en_d     = irq_en_q;
    lowwater_d   = lowwater_q;
    scratch_d    = scratch_q;
    underflow_d  = underflow_q;
    overrun_d    = overrun_q;
    lw_pending_d = lw_pending_q;
    level_next_b = '0;
    level_next_b[DEPTH_LOG2-1:0] = level_next;

    if (wr_ctrl) begin
      enable_d   = sram_d_in[CTRL_ENABLE];
      dma_mode_d = sram_d_in[CTRL_DMA_MODE];
      mute_d     = sram_d_in[CTRL_MUTE];
      irq_en_d   = sram_d_in[CTRL_IRQ_EN];
      if (sram_d_in[CTRL_CLR_UNDERFLOW] || sram_d_in[CTRL_FLUSH]) underflow_d = 1'b0;
    end
    if (wr_lowwater) lowwater_d = sram_d_in;
    if (wr_scratch)  scratch_d  = sram_d_in;
    if (wr_irqclr) begin
      overrun_d    = 1'b0;
      lw_pending_d = 1'b0;
    end
    if (consume_ok && empty)                     underflow_d  = 1'b1;
    if (dma_mode_q && dma_strobe && full)        overrun_d    = 1'b1;
    if (consume_ok && level_next_b < lowwater_q) lw_pending_d = 1'b1;

    out_enable_d = out_enable_q;
    if (enable_d)     out_enable_d = 1'b1;
    else if (consume) out_enable_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q     <= 1'b0;
      dma_mode_q   <= 1'b0;
      mute_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      underflow_q  <= 1'b0;
      overrun_q    <= 1'b0;
      lw_pending_q <= 1'b0;
      out_enable_q <= 1'b0;
      rdpos_q      <= '0;
      wrpos_q      <= '0;
      bytecnt_q    <= '0;
      lowwater_q   <= '0;
      scratch_q    <= SCRATCH_RESET;
    end else begin
      enable_q     <= enable_d;
      dma_mode_q   <= dma_mode_d;
      mute_q       <= mute_d;
      irq_en_q     <= irq_en_d;
      underflow_q  <= underflow_d;
      overrun_q    <= overrun_d;
      lw_pending_q <= lw_pending_d;
      out_enable_q <= out_enable_d;
      rdpos_q      <= rdpos_d;
      wrpos_q      <= wrpos_d;
      bytecnt_q    <= bytecnt_d;
      lowwater_q   <= lowwater_d;
      scratch_q    <= scratch_d;
    end
  end

  // The CPU owns the single RAM write port when both sides write in the same cycle.
  always_comb begin
    ram_we    = buf_wr | dma_wr;
    ram_waddr = buf_wr ? sram_a[BAW-1:0] : {wrpos_q, bytecnt_q};
    ram_wdata = buf_wr ? sram_d_in : dma_data;
  end

  cdda_frame_ram #(
    .CHANNELS   (CHANNELS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_frame_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .rd_frame (rdpos_q),
    .rd_data  (ram_rd_data)
  );

  always_comb begin
    level_b = '0;
    rdpos_b = '0;
    wrpos_b = '0;
    level_b[DEPTH_LOG2-1:0] = level;
    rdpos_b[DEPTH_LOG2-1:0] = rdpos_q;
    wrpos_b[DEPTH_LOG2-1:0] = wrpos_q;
    sram_d_out = '0;
    if (sram_cs && sram_oe && !sram_a[AW-1]) begin
      unique case (reg_sel)
        REG_CTRL: begin
          sram_d_out[CTRL_ENABLE]   = enable_q;
          sram_d_out[CTRL_DMA_MODE] = dma_mode_q;
          sram_d_out[CTRL_MUTE]     = mute_q;
          sram_d_out[CTRL_IRQ_EN]   = irq_en_q;
        end
        REG_STATUS: begin
          sram_d_out[ST_ENABLED]    = enable_q;
          sram_d_out[ST_UNDERFLOW]  = underflow_q;
          sram_d_out[ST_OVERRUN]    = overrun_q;
          sram_d_out[ST_LW_PENDING] = lw_pending_q;
          sram_d_out[ST_EMPTY]      = empty;
          sram_d_out[ST_FULL]       = full;
        end
        REG_RDPOS:    sram_d_out = rdpos_b;
        REG_WRPOS:    sram_d_out = wrpos_b;
        REG_LEVEL:    sram_d_out = level_b;
        REG_LOWWATER: sram_d_out = lowwater_q;
        REG_SCRATCH:  sram_d_out = scratch_q;
        REG_IRQCLR:   sram_d_out = '0;
        default:      sram_d_out = '0;
      endcase
    end
  end

  assign out_data   = (underflow_q & mute_q) ? '0 : ram_rd_data;
  assign out_enable = out_enable_q;
  assign irq        = lw_pending_q & irq_en_q;
  assign sram_wait  = 1'b0;

endmodule

// File: tb/tb_cdda_ring_interface.sv
// Directed self-checking bench for cdda_ring_interface at default parameters
// (2 channels, 256-frame ring).
module tb_cdda_ring_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] sram_a = '0;
  logic [7:0]  sram_d_in = '0;
  logic [7:0]  sram_d_out;
  logic        sram_cs = 1'b0, sram_oe = 1'b0, sram_we = 1'b0;
  logic        sram_wait;
  logic [7:0]  dma_data = '0;
  logic        dma_strobe = 1'b0;
  logic        consume = 1'b0;
  logic [31:0] out_data;
  logic        out_enable;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  cdda_ring_interface dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sram_a     (sram_a),
    .sram_d_in  (sram_d_in),
    .sram_d_out (sram_d_out),
    .sram_cs    (sram_cs),
    .sram_oe    (sram_oe),
    .sram_we    (sram_we),
    .sram_wait  (sram_wait),
    .dma_data   (dma_data),
    .dma_strobe (dma_strobe),
    .consume    (consume),
    .out_data   (out_data),
    .out_enable (out_enable),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    sram_a = a; sram_d_in = d; sram_cs = 1'b1; sram_we = 1'b1;
    @(negedge clk);
    sram_cs = 1'b0; sram_we = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] off, input logic [7:0] d);
    cpu_write({8'h00, off}, d);
  endtask

  task automatic reg_read(input logic [2:0] off, output logic [7:0] d);
    @(negedge clk);
    sram_a = {8'h00, off}; sram_cs = 1'b1; sram_oe = 1'b1;
    #1 d = sram_d_out;
    sram_cs = 1'b0; sram_oe = 1'b0;
  endtask

  task automatic dma_byte(input logic [7:0] d);
    @(negedge clk);
    dma_data = d; dma_strobe = 1'b1;
    @(negedge clk);
    dma_strobe = 1'b0;
  endtask

  task automatic pulse_consume();
    @(negedge clk);
    consume = 1'b1;
    @(negedge clk);
    consume = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] exp_regs [8] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00};
    rst_n = 1'b0;
    idle(2);
    tests_run++;
    if (out_data !== 32'h0 || out_enable !== 1'b0 || irq !== 1'b0 || sram_wait !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got data=%h en=%b irq=%b wait=%b, expected 0/0/0/0",
               out_data, out_enable, irq, sram_wait);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      reg_read(3'(i), rd);
      tests_run++;
      if (rd !== exp_regs[i]) begin
        tests_failed++;
        $display("[TB] FAIL reset_reg%0d: got %h expected %h", i, rd, exp_regs[i]);
      end
    end
  endtask

  task automatic test_dma_fill();
    logic [7:0] rd;
    do_reset();
    reg_write(3'd0, 8'h05);
    tests_run++;
    if (out_enable !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL dma_out_enable: got %b expected 1", out_enable);
    end
    for (int i = 1; i <= 8; i++) dma_byte(8'(i));
    reg_read(3'd3, rd);
    tests_run++;
    if (rd !== 8'h02) begin
      tests_failed++;
      $display("[TB] FAIL dma_wrpos: got %h expected 02", rd);
    end
    reg_read(3'd4, rd);
    tests_run++;
    if (rd !== 8'h02) begin
      tests_failed++;
      $display("[TB] FAIL dma_level: got %h expected 02", rd);
    end
    tests_run++;
    if (out_data !== 32'h04030201) begin
      tests_failed++;
      $display("[TB] FAIL dma_frame0: got %h expected 04030201", out_data);
    end
    pulse_consume();
    idle(1);
    tests_run++;
    if (out_data !== 32'h08070605) begin
      tests_failed++;
      $display("[TB] FAIL dma_frame1: got %h expected 08070605", out_data);
    end
    reg_read(3'd4, rd);
    tests_run++;
    if (rd !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL dma_level_after_consume: got %h expected 01", rd);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] rd;
    do_reset();
    reg_write(3'd0, 8'h09);
    idle(1);
    tests_run++;
    if (out_data !== 32'h04030201) begin
      tests_failed++;
      $display("[TB] FAIL ram_kept_over_reset: got %h expected 04030201", out_data);
    end
    pulse_consume();
    tests_run++;
    if (out_data !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL underflow_mute: got %h expected 00000000", out_data);
    end
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 8'h13) begin
      tests_failed++;
      $display("[TB] FAIL underflow_status: got %h expected 13", rd);
    end
    reg_read(3'd2, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL underflow_rdpos: got %h expected 00", rd);
    end
    reg_write(3'd0, 8'h0B);
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 8'h11) begin
      tests_failed++;
      $display("[TB] FAIL underflow_clear: got %h expected 11", rd);
    end
    reg_read(3'd0, rd);
    tests_run++;
    if (rd !== 8'h09) begin
      tests_failed++;
      $display("[TB] FAIL ctrl_readback: got %h expected 09", rd);
    end
    tests_run++;
    if (out_data !== 32'h04030201) begin
      tests_failed++;
      $display("[TB] FAIL unmute_after_clear: got %h expected 04030201", out_data);
    end
  endtask

  task automatic test_cpu_buffer_flush();
    logic [7:0] rd;
    logic [7:0] bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    for (int i = 0; i < 4; i++) cpu_write({1'b1, 10'(i)}, bytes[i]);
    idle(1);
    tests_run++;
    if (out_data !== 32'hDDCCBBAA) begin
      tests_failed++;
      $display("[TB] FAIL cpu_buffer_write: got %h expected DDCCBBAA", out_data);
    end
    reg_read(3'd4, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL cpu_buffer_level: got %h expected 00", rd);
    end
    reg_write(3'd3, 8'h07);
    reg_write(3'd0, 8'h20);
    reg_read(3'd2, rd);
    tests_run++;
    if (rd !== 8'h07) begin
      tests_failed++;
      $display("[TB] FAIL flush_rdpos: got %h expected 07", rd);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] rd;
    do_reset();
    reg_write(3'd0, 8'h04);
    reg_write(3'd3, 8'hFE);
    reg_write(3'd2, 8'hFF);
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 8'h20) begin
      tests_failed++;
      $display("[TB] FAIL full_at_wrpos_fe_rdpos_ff: got %h expected 20", rd);
    end
    // RDPOS 0 leaves exactly one free frame before the ring fills at WRPOS 0xFF.
    reg_write(3'd2, 8'h00);
    for (int i = 0; i < 4; i++) dma_byte(8'h10 + 8'(i));
    reg_read(3'd3, rd);
    tests_run++;
    if (rd !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL overrun_wrpos_before: got %h expected FF", rd);
    end
    for (int i = 0; i < 4; i++) dma_byte(8'h20 + 8'(i));
    reg_read(3'd3, rd);
    tests_run++;
    if (rd !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL overrun_wrpos_after: got %h expected FF", rd);
    end
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 8'h24) begin
      tests_failed++;
      $display("[TB] FAIL overrun_status: got %h expected 24", rd);
    end
    reg_write(3'd2, 8'h01);
    for (int i = 0; i < 4; i++) dma_byte(8'h30 + 8'(i));
    reg_read(3'd3, rd);
    tests_run++;
    if (rd !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL wrpos_wrap: got %h expected 00", rd);
    end
    reg_write(3'd7, 8'h00);
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 8'h20) begin
      tests_failed++;
      $display("[TB] FAIL irqclr_overrun: got %h expected 20", rd);
    end
  endtask

  task automatic test_low_water();
    logic [7:0] rd;
    do_reset();
    reg_write(3'd0, 8'h11);
    reg_write(3'd5, 8'h03);
    reg_write(3'd3, 8'h03);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lw_irq_idle: got %b expected 0", irq);
    end
    pulse_consume();
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL lw_irq_set: got %b expected 1", irq);
    end
    reg_read(3'd1, rd);
    tests_run++;
    if (rd !== 8'h09) begin
      tests_failed++;
      $display("[TB] FAIL lw_status: got %h expected 09", rd);
    end
    reg_write(3'd7, 8'hFF);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lw_irq_clear: got %b expected 0", irq);
    end
    reg_write(3'd0, 8'h00);
    tests_run++;
    if (out_enable !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL out_enable_hold: got %b expected 1", out_enable);
    end
    pulse_consume();
    tests_run++;
    if (out_enable !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL out_enable_drop: got %b expected 0", out_enable);
    end
    reg_read(3'd2, rd);
    tests_run++;
    if (rd !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL disabled_consume_rdpos: got %h expected 01", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic [7:0] exp_regs [7] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
    do_reset();
    reg_write(3'd0, 8'h05);
    reg_write(3'd3, 8'h05);
    for (int i = 0; i < 3; i++) dma_byte(8'h40 + 8'(i));
    @(negedge clk);
    dma_data = 8'h43; dma_strobe = 1'b1; consume = 1'b1;
    @(negedge clk);
    dma_strobe = 1'b0; consume = 1'b0;
    reg_read(3'd4, rd);
    tests_run++;
    if (rd !== 8'h05) begin
      tests_failed++;
      $display("[TB] FAIL b2b_level: got %h expected 05", rd);
    end
    reg_read(3'd2, rd);
    tests_run++;
    if (rd !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL b2b_rdpos: got %h expected 01", rd);
    end
    reg_read(3'd3, rd);
    tests_run++;
    if (rd !== 8'h06) begin
      tests_failed++;
      $display("[TB] FAIL b2b_wrpos: got %h expected 06", rd);
    end
    dma_byte(8'h50);
    dma_byte(8'h51);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_data !== 32'h0 || out_enable !== 1'b0 || irq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset_outputs: got data=%h en=%b irq=%b, expected 0/0/0",
               out_data, out_enable, irq);
    end
    for (int i = 0; i < 7; i++) begin
      reg_read(3'(i), rd);
      tests_run++;
      if (rd !== exp_regs[i]) begin
        tests_failed++;
        $display("[TB] FAIL midframe_reset_reg%0d: got %h expected %h", i, rd, exp_regs[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    reg_write(3'd0, 8'h04);
    for (int i = 0; i < 4; i++) dma_byte(8'h60 + 8'(i));
    reg_read(3'd3, rd);
    tests_run++;
    if (rd !== 8'h01) begin
      tests_failed++;
      $display("[TB] FAIL partial_frame_discarded: got %h expected 01", rd);
    end
  endtask

  initial begin
    test_reset();
    test_dma_fill();
    test_underflow();
    test_cpu_buffer_flush();
    test_overrun();
    test_low_water();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
